// File: rtl/oam_responder_if.sv
// oam_responder_if
//   Strobe and scan-stream bundle between the bus masters / PPU and the
//   object attribute memory responder. The shared addr_ext/data_ext
//   tristate bus is not part of this bundle; it stays on the module ports.
//
//   master : CPU/DMA strobes and PPU scan request (drives), scan stream (reads)
//   slave  : oam_responder side
interface oam_responder_if;
    logic       mem_re;
    logic       mem_we;
    logic       dma_mem_re;
    logic       dma_mem_we;
    logic       scan_start;
    logic [7:0] ly;
    logic       obj_tall;
    logic       scan_busy;
    logic       scan_valid;
    logic [5:0] scan_index;
    logic [7:0] scan_y;
    logic [7:0] scan_x;
    logic [7:0] scan_tile;
    logic [7:0] scan_attr;
    logic       scan_hit;
    logic       scan_done;

    modport master (
        output mem_re, mem_we, dma_mem_re, dma_mem_we,
        output scan_start, ly, obj_tall,
        input  scan_busy, scan_valid, scan_index,
        input  scan_y, scan_x, scan_tile, scan_attr,
        input  scan_hit, scan_done
    );

    modport slave (
        input  mem_re, mem_we, dma_mem_re, dma_mem_we,
        input  scan_start, ly, obj_tall,
        output scan_busy, scan_valid, scan_index,
        output scan_y, scan_x, scan_tile, scan_attr,
        output scan_hit, scan_done
    );
endinterface

// File: rtl/oam_responder.sv
// oam_responder
//   Object attribute memory (4*ENTRIES bytes at 0xFE00) on the shared
//   tristate bus, plus the per-line object scan engine feeding the PPU.
//   The CPU is locked out (reads 0xFF, writes dropped) while a scan runs;
//   DMA accesses are always honoured and take priority over CPU strobes.
//
// Ports
//   clock     : CPU clock
//   reset     : asynchronous, active-high
//   addr_ext  : shared address bus, only observed
//   data_ext  : shared data bus, driven combinationally on decoded reads
//   bus       : oam_responder_if.slave (strobes, scan request, scan stream)
//
// Build option
//   OAM_SCAN_FILTER_EN : report only in-range entries, at most MAX_HITS per scan
//
// state | meaning
// IDLE  | waiting for scan_start
// FETCH | register the 4 bytes of entry[index]
// EMIT  | present registered entry on the scan stream
// DONE  | one-cycle scan_done pulse
module oam_responder #(
    parameter int ENTRIES  = 40,
    parameter int MAX_HITS = 10
) (
    input  logic           clock,
    input  logic           reset,
    inout  wire  [15:0]    addr_ext,
    inout  wire  [7:0]     data_ext,
    oam_responder_if.slave bus
);
    localparam int          BYTES    = 4 * ENTRIES;
    localparam logic [15:0] BASE     = 16'hFE00;
    localparam logic [15:0] LAST     = BASE + 16'(BYTES - 1);
    localparam logic [5:0]  LAST_IDX = 6'(ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] mem [BYTES];
    logic [5:0] index;
    logic [7:0] ent_y;
    logic [7:0] ent_x;
    logic [7:0] ent_tile;
    logic [7:0] ent_attr;
    logic [7:0] line;
    logic       tall;
    logic       busy;
    logic       emit;
    logic       done;
    logic       hit;
    logic       valid;

    // ---------------- bus side ----------------
    logic       sel;
    logic       is_dma;
    logic       rd_en;
    logic       wr_en;
    logic [7:0] offset;
    logic [7:0] rd_data;

    assign sel    = (addr_ext >= BASE) && (addr_ext <= LAST);
    assign offset = 8'(addr_ext - BASE);
    assign is_dma = bus.dma_mem_re || bus.dma_mem_we;
    // Drive is released as soon as reset asserts, not at the next edge.
    assign rd_en  = sel && (bus.mem_re || bus.dma_mem_re) && !reset;
    assign rd_data = (is_dma || !busy) ? mem[offset] : 8'hFF;
    assign wr_en  = sel && (is_dma ? bus.dma_mem_we : (bus.mem_we && !busy));

    assign data_ext = rd_en ? rd_data : 8'bz;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BYTES; i++) mem[i] <= 8'h00;
        end else if (wr_en) begin
            mem[offset] <= data_ext;
        end
    end

    // ---------------- scan FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        emit      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.scan_start) state_nxt = FETCH;
            end
            FETCH: begin
                busy      = 1'b1;
                state_nxt = EMIT;
            end
            EMIT: begin
                busy      = 1'b1;
                emit      = 1'b1;
                state_nxt = (index == LAST_IDX) ? DONE : FETCH;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A DMA write landing on the entry being fetched stores the new byte
    // while the scan registers the old one (same-edge read-before-write).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index    <= '0;
            ent_y    <= '0;
            ent_x    <= '0;
            ent_tile <= '0;
            ent_attr <= '0;
            line     <= '0;
            tall     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.scan_start) begin
                        index <= '0;
                        line  <= bus.ly;
                        tall  <= bus.obj_tall;
                    end
                end
                FETCH: begin
                    ent_y    <= mem[{index, 2'b00}];
                    ent_x    <= mem[{index, 2'b01}];
                    ent_tile <= mem[{index, 2'b10}];
                    ent_attr <= mem[{index, 2'b11}];
                end
                EMIT: begin
                    if (index != LAST_IDX) index <= index + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Screen line t sits 16 above object Y space; 9 bits keep y+h from wrapping.
    logic [8:0] t_line;
    logic [8:0] y_top;
    logic [8:0] y_end;

    assign t_line = {1'b0, line} + 9'd16;
    assign y_top  = {1'b0, ent_y};
    assign y_end  = y_top + (tall ? 9'd16 : 9'd8);
    assign hit    = (t_line >= y_top) && (t_line < y_end);

`ifdef OAM_SCAN_FILTER_EN
    logic [3:0] hit_cnt;

    assign valid = emit && hit && (hit_cnt < 4'(MAX_HITS));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                               hit_cnt <= '0;
        else if (state == IDLE && bus.scan_start) hit_cnt <= '0;
        else if (valid)                          hit_cnt <= hit_cnt + 4'd1;
    end

    assign bus.scan_hit = valid;
`else
    assign valid        = emit;
    assign bus.scan_hit = emit && hit;
`endif

    assign bus.scan_busy  = busy;
    assign bus.scan_valid = valid;
    assign bus.scan_done  = done;
    assign bus.scan_index = index;
    assign bus.scan_y     = ent_y;
    assign bus.scan_x     = ent_x;
    assign bus.scan_tile  = ent_tile;
    assign bus.scan_attr  = ent_attr;
endmodule

// File: tb/tb_oam_responder.sv
// tb_oam_responder
//   Directed bench for oam_responder: bus decode/read/write, CPU lockout,
//   scan timing, hit boundaries, optional hit filter and mid-scan reset.
//   Expected values come from hand-computed constants and a byte model
//   of the memory kept by the bench. Build with OAM_SCAN_FILTER_EN to
//   exercise the filtered variant.
module tb_oam_responder;
    localparam int ENTRIES  = 40;
    localparam int MAX_HITS = 10;
`ifdef OAM_SCAN_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] tb_addr;
    logic [7:0]  tb_wdata;
    logic        tb_oe;
    wire  [15:0] addr_ext;
    wire  [7:0]  data_ext;

    assign addr_ext = tb_addr;
    assign data_ext = tb_oe ? tb_wdata : 8'bz;
    pullup (data_ext);

    oam_responder_if bus_if ();

    oam_responder dut (
        .clock    (clock),
        .reset    (reset),
        .addr_ext (addr_ext),
        .data_ext (data_ext),
        .bus      (bus_if.slave)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model [4*ENTRIES];
    logic [7:0] img   [4*ENTRIES];

    function automatic logic model_hit(input logic [7:0] y, input logic [7:0] ly, input logic tall);
        int t;
        int h;
        t = int'(ly) + 16;
        h = tall ? 16 : 8;
        return (t >= int'(y)) && (t < int'(y) + h);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic dma_write(input logic [15:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_wdata = d;
        tb_oe = 1'b1;
        bus_if.dma_mem_we = 1'b1;
        tick();
        bus_if.dma_mem_we = 1'b0;
        tb_oe = 1'b0;
        model[int'(a) - 'hFE00] = d;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic dma, output logic [7:0] obs);
        tb_addr = a;
        if (dma) bus_if.dma_mem_re = 1'b1;
        else     bus_if.mem_re = 1'b1;
        @(negedge clock);
        obs = data_ext;
        tick();
        bus_if.mem_re = 1'b0;
        bus_if.dma_mem_re = 1'b0;
    endtask

    task automatic start_scan(input logic [7:0] ly, input logic tall);
        bus_if.scan_start = 1'b1;
        bus_if.ly = ly;
        bus_if.obj_tall = tall;
        tick();
        bus_if.scan_start = 1'b0;
        bus_if.ly = 8'hFF;
        bus_if.obj_tall = ~tall;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if (bus_if.scan_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus_if.scan_busy); end
        n_checks++; if (bus_if.scan_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus_if.scan_valid); end
        n_checks++; if (bus_if.scan_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus_if.scan_done); end
        n_checks++; if (bus_if.scan_index !== 6'd0) begin n_fail++; $display("FAIL reset_index: got %0d expected 0", bus_if.scan_index); end
        n_checks++; if ({bus_if.scan_y, bus_if.scan_x, bus_if.scan_tile, bus_if.scan_attr} !== 32'h0) begin
            n_fail++; $display("FAIL reset_entry: got %h expected 00000000", {bus_if.scan_y, bus_if.scan_x, bus_if.scan_tile, bus_if.scan_attr}); end
        n_checks++; if (bus_if.scan_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b expected 0", bus_if.scan_hit); end
        tick();
        bus_read(16'hFE05, 1'b0, obs);
        n_checks++; if (obs !== 8'h00) begin n_fail++; $display("FAIL reset_mem_fe05: got %h expected 00", obs); end
        bus_read(16'hFE9F, 1'b1, obs);
        n_checks++; if (obs !== 8'h00) begin n_fail++; $display("FAIL reset_mem_fe9f: got %h expected 00", obs); end
    endtask

    task automatic test_dma_fill();
        logic [7:0] obs;
        for (int n = 0; n < 4*ENTRIES; n++) dma_write(16'(16'hFE00 + n), 8'(n) ^ 8'h5A);
        bus_read(16'hFE05, 1'b0, obs);
        n_checks++; if (obs !== 8'h5F) begin n_fail++; $display("FAIL fill_fe05: got %h expected 5f", obs); end
        bus_read(16'hFE00, 1'b0, obs);
        n_checks++; if (obs !== 8'h5A) begin n_fail++; $display("FAIL fill_fe00: got %h expected 5a", obs); end
        bus_read(16'hFE9F, 1'b0, obs);
        n_checks++; if (obs !== 8'hC5) begin n_fail++; $display("FAIL fill_fe9f: got %h expected c5", obs); end
        bus_read(16'hFE10, 1'b1, obs);
        n_checks++; if (obs !== 8'h4A) begin n_fail++; $display("FAIL fill_dma_fe10: got %h expected 4a", obs); end
        // Undecoded addresses leave the bus to the pull-up.
        bus_read(16'hFEA0, 1'b0, obs);
        n_checks++; if (obs !== 8'hFF) begin n_fail++; $display("FAIL undecoded_fea0: got %h expected ff (released)", obs); end
        bus_read(16'hFEFF, 1'b1, obs);
        n_checks++; if (obs !== 8'hFF) begin n_fail++; $display("FAIL undecoded_feff: got %h expected ff (released)", obs); end
        bus_read(16'hFDFF, 1'b0, obs);
        n_checks++; if (obs !== 8'hFF) begin n_fail++; $display("FAIL undecoded_fdff: got %h expected ff (released)", obs); end
        // Idle CPU write is stored.
        tb_addr = 16'hFE02; tb_wdata = 8'h11; tb_oe = 1'b1; bus_if.mem_we = 1'b1;
        tick();
        bus_if.mem_we = 1'b0; tb_oe = 1'b0; model[2] = 8'h11;
        bus_read(16'hFE02, 1'b0, obs);
        n_checks++; if (obs !== 8'h11) begin n_fail++; $display("FAIL cpu_write_idle: got %h expected 11", obs); end
    endtask

    task automatic test_scan_timing();
        logic [7:0] obs;
        int         k;
        int         nh;
        int         npulse;
        logic       e_hit;
        logic       e_valid;
        for (int i = 0; i < 4*ENTRIES; i++) img[i] = model[i];
        nh = 0;
        npulse = 0;
        start_scan(8'd0, 1'b0);
        for (int c = 1; c <= 84; c++) begin
            case (c)
                10: begin tb_addr = 16'hFE00; tb_wdata = 8'h77; tb_oe = 1'b1; bus_if.mem_we = 1'b1; end
                11: begin tb_addr = 16'hFE01; bus_if.mem_re = 1'b1; end
                12: begin tb_addr = 16'hFE04; tb_wdata = 8'h33; tb_oe = 1'b1; bus_if.dma_mem_we = 1'b1; end
                21: begin tb_addr = 16'hFE28; tb_wdata = 8'hC3; tb_oe = 1'b1; bus_if.dma_mem_we = 1'b1; end
                40, 81: bus_if.scan_start = 1'b1;
                default: ;
            endcase
            @(negedge clock);
            n_checks++; if (bus_if.scan_busy !== (c <= 80)) begin n_fail++; $display("FAIL timing_busy c=%0d: got %b expected %b", c, bus_if.scan_busy, (c <= 80)); end
            n_checks++; if (bus_if.scan_done !== (c == 81)) begin n_fail++; $display("FAIL timing_done c=%0d: got %b expected %b", c, bus_if.scan_done, (c == 81)); end
            if (c == 11) begin
                n_checks++; if (data_ext !== 8'hFF) begin n_fail++; $display("FAIL lockout_read: got %h expected ff", data_ext); end
            end
            if (c >= 2 && c <= 80 && (c % 2) == 0) begin
                k = (c - 2) / 2;
                e_hit = model_hit(img[4*k], 8'd0, 1'b0);
                e_valid = FILTER ? (e_hit && nh < MAX_HITS) : 1'b1;
                if (FILTER && e_valid) nh++;
                if (bus_if.scan_valid === 1'b1) npulse++;
                n_checks++; if (bus_if.scan_valid !== e_valid) begin n_fail++; $display("FAIL timing_valid c=%0d: got %b expected %b", c, bus_if.scan_valid, e_valid); end
                n_checks++; if (bus_if.scan_hit !== (FILTER ? e_valid : e_hit)) begin n_fail++; $display("FAIL timing_hit k=%0d: got %b expected %b", k, bus_if.scan_hit, (FILTER ? e_valid : e_hit)); end
                if (e_valid) begin
                    n_checks++; if (bus_if.scan_index !== 6'(k)) begin n_fail++; $display("FAIL timing_index c=%0d: got %0d expected %0d", c, bus_if.scan_index, k); end
                    n_checks++; if ({bus_if.scan_y, bus_if.scan_x, bus_if.scan_tile, bus_if.scan_attr} !== {img[4*k], img[4*k+1], img[4*k+2], img[4*k+3]}) begin
                        n_fail++; $display("FAIL timing_entry k=%0d: got %h expected %h", k, {bus_if.scan_y, bus_if.scan_x, bus_if.scan_tile, bus_if.scan_attr}, {img[4*k], img[4*k+1], img[4*k+2], img[4*k+3]}); end
                end
            end else begin
                n_checks++; if (bus_if.scan_valid !== 1'b0) begin n_fail++; $display("FAIL timing_valid_off c=%0d: got %b expected 0", c, bus_if.scan_valid); end
            end
            tick();
            if (c == 12) model[4] = 8'h33;
            if (c == 21) model[40] = 8'hC3;
            bus_if.mem_we = 1'b0; bus_if.mem_re = 1'b0; bus_if.dma_mem_we = 1'b0; tb_oe = 1'b0;
            bus_if.scan_start = 1'b0;
        end
        n_checks++; if (npulse !== (FILTER ? 2 : 40)) begin n_fail++; $display("FAIL timing_pulses: got %0d expected %0d", npulse, (FILTER ? 2 : 40)); end
        bus_read(16'hFE04, 1'b0, obs);
        n_checks++; if (obs !== 8'h33) begin n_fail++; $display("FAIL lockout_dma_write: got %h expected 33", obs); end
        bus_read(16'hFE00, 1'b0, obs);
        n_checks++; if (obs !== 8'h5A) begin n_fail++; $display("FAIL lockout_cpu_write_dropped: got %h expected 5a", obs); end
        bus_read(16'hFE28, 1'b1, obs);
        n_checks++; if (obs !== 8'hC3) begin n_fail++; $display("FAIL fetch_cycle_dma_write: got %h expected c3", obs); end
    endtask

    task automatic test_hit_boundaries();
        logic [4:0] tbl;
        logic [7:0] ys;
        int         k;
        logic       e_hit;
        for (int e = 0; e < ENTRIES; e++) begin
            case (e)
                0: ys = 8'd16;
                1: ys = 8'd9;
                2: ys = 8'd8;
                3: ys = 8'd17;
                4: ys = 8'd1;
                default: ys = 8'hA0;
            endcase
            dma_write(16'(16'hFE00 + 4*e), ys);
        end
        for (int tall = 0; tall < 2; tall++) begin
            tbl = (tall == 1) ? 5'b10111 : 5'b00011;
            start_scan(8'd0, tall[0]);
            for (int c = 1; c <= 81; c++) begin
                @(negedge clock);
                if (c >= 2 && c <= 80 && (c % 2) == 0) begin
                    k = (c - 2) / 2;
                    e_hit = (k < 5) ? tbl[k] : 1'b0;
                    n_checks++; if (bus_if.scan_hit !== e_hit) begin n_fail++; $display("FAIL hit_tall%0d_k%0d: got %b expected %b", tall, k, bus_if.scan_hit, e_hit); end
                    n_checks++; if (bus_if.scan_valid !== (FILTER ? e_hit : 1'b1)) begin n_fail++; $display("FAIL hit_valid_tall%0d_k%0d: got %b expected %b", tall, k, bus_if.scan_valid, (FILTER ? e_hit : 1'b1)); end
                end
                if (c == 81) begin
                    n_checks++; if (bus_if.scan_done !== 1'b1) begin n_fail++; $display("FAIL hit_done_tall%0d: got %b expected 1", tall, bus_if.scan_done); end
                end
                tick();
            end
        end
    endtask

    task automatic test_filter();
        int   k;
        int   npulse;
        int   nhits;
        logic e_valid;
        logic e_hit;
        for (int e = 0; e < ENTRIES; e++) dma_write(16'(16'hFE00 + 4*e), (e < 12) ? 8'd16 : 8'hA0);
        npulse = 0;
        nhits = 0;
        start_scan(8'd0, 1'b0);
        for (int c = 1; c <= 84; c++) begin
            @(negedge clock);
            if (bus_if.scan_valid === 1'b1) npulse++;
            if (bus_if.scan_valid === 1'b1 && bus_if.scan_hit === 1'b1) nhits++;
            if (c >= 2 && c <= 80 && (c % 2) == 0) begin
                k = (c - 2) / 2;
                e_valid = FILTER ? (k < MAX_HITS) : 1'b1;
                e_hit = FILTER ? (k < MAX_HITS) : (k < 12);
                n_checks++; if (bus_if.scan_valid !== e_valid) begin n_fail++; $display("FAIL filter_valid k=%0d: got %b expected %b", k, bus_if.scan_valid, e_valid); end
                n_checks++; if (bus_if.scan_hit !== e_hit) begin n_fail++; $display("FAIL filter_hit k=%0d: got %b expected %b", k, bus_if.scan_hit, e_hit); end
            end
            n_checks++; if (bus_if.scan_busy !== (c <= 80)) begin n_fail++; $display("FAIL filter_busy c=%0d: got %b expected %b", c, bus_if.scan_busy, (c <= 80)); end
            n_checks++; if (bus_if.scan_done !== (c == 81)) begin n_fail++; $display("FAIL filter_done c=%0d: got %b expected %b", c, bus_if.scan_done, (c == 81)); end
            tick();
        end
        n_checks++; if (npulse !== (FILTER ? 10 : 40)) begin n_fail++; $display("FAIL filter_pulses: got %0d expected %0d", npulse, (FILTER ? 10 : 40)); end
        n_checks++; if (nhits !== (FILTER ? 10 : 12)) begin n_fail++; $display("FAIL filter_hit_count: got %0d expected %0d", nhits, (FILTER ? 10 : 12)); end
    endtask

    task automatic test_reset_mid_scan();
        logic [7:0] obs;
        dma_write(16'hFE05, 8'hAB);
        start_scan(8'd0, 1'b0);
        repeat (29) tick();
        // now in cycle 30: EMIT of entry 14, with a DMA read in flight
        tb_addr = 16'hFE05;
        bus_if.dma_mem_re = 1'b1;
        #1;
        n_checks++; if (bus_if.scan_busy !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_busy: got %b expected 1", bus_if.scan_busy); end
        n_checks++; if (data_ext !== 8'hAB) begin n_fail++; $display("FAIL midreset_pre_read: got %h expected ab", data_ext); end
        reset = 1'b1;
        #1;
        n_checks++; if (bus_if.scan_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", bus_if.scan_busy); end
        n_checks++; if (bus_if.scan_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", bus_if.scan_valid); end
        n_checks++; if (bus_if.scan_index !== 6'd0) begin n_fail++; $display("FAIL midreset_index: got %0d expected 0", bus_if.scan_index); end
        n_checks++; if ({bus_if.scan_y, bus_if.scan_x, bus_if.scan_tile, bus_if.scan_attr} !== 32'h0) begin
            n_fail++; $display("FAIL midreset_entry: got %h expected 00000000", {bus_if.scan_y, bus_if.scan_x, bus_if.scan_tile, bus_if.scan_attr}); end
        n_checks++; if (data_ext !== 8'hFF) begin n_fail++; $display("FAIL midreset_bus_release: got %h expected ff (released)", data_ext); end
        bus_if.dma_mem_re = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4*ENTRIES; i++) model[i] = 8'h00;
        @(negedge clock);
        n_checks++; if (bus_if.scan_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_post_busy: got %b expected 0", bus_if.scan_busy); end
        tick();
        bus_read(16'hFE05, 1'b0, obs);
        n_checks++; if (obs !== 8'h00) begin n_fail++; $display("FAIL midreset_mem_cleared: got %h expected 00", obs); end
    endtask

    initial begin
        reset = 1'b1;
        tb_addr = 16'h0000;
        tb_wdata = 8'h00;
        tb_oe = 1'b0;
        bus_if.mem_re = 1'b0;
        bus_if.mem_we = 1'b0;
        bus_if.dma_mem_re = 1'b0;
        bus_if.dma_mem_we = 1'b0;
        bus_if.scan_start = 1'b0;
        bus_if.ly = 8'h00;
        bus_if.obj_tall = 1'b0;
        for (int i = 0; i < 4*ENTRIES; i++) model[i] = 8'h00;
        test_reset();
        test_dma_fill();
        test_scan_timing();
        test_hit_boundaries();
        test_filter();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
